// File: rtl/pipe_stage_buf_if.sv
// Valid/ready beat bus between two pipeline stages: handshake plus control and data fields.
// The master drives the beat; the slave answers with ready.
interface pipe_stage_buf_if #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 128
) ();
    logic              valid;
    logic              ready;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;

    modport master (output valid, output ctrl, output data, input ready);
    modport slave  (input valid, input ctrl, input data, output ready);
endinterface

// File: rtl/pipe_stage_buf.sv
// Valid/ready pipeline stage register with stall, flush and an optional 2-entry skid buffer.
// Flush zeroes the control field of held beats; the data field keeps its last value.
module pipe_stage_buf #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 128,
    parameter int SKID   = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    pipe_stage_buf_if.slave   up,
    pipe_stage_buf_if.master  dn,
    input  logic              flush_i,
    output logic [1:0]        count_o
);
    localparam bit HAS_SKID = (SKID != 0);

    logic              rst_done;
    logic              ready;
    logic              in_fire;
    logic              out_fire;
    logic              m_free;

    logic              m_vld_p1, m_vld_n;
    logic [CTRL_W-1:0] m_ctrl_p1, m_ctrl_n;
    logic [DATA_W-1:0] m_data_p1, m_data_n;
    logic              s_vld_p1, s_vld_n;
    logic [CTRL_W-1:0] s_ctrl_p1, s_ctrl_n;
    logic [DATA_W-1:0] s_data_p1, s_data_n;

    // With a skid entry ready depends only on flops; without it ready looks through to ready_i.
    always_comb begin
        if (HAS_SKID) ready = rst_done & ~s_vld_p1;
        else          ready = rst_done & (~m_vld_p1 | dn.ready);
    end

    assign in_fire  = up.valid & ready;
    assign out_fire = m_vld_p1 & dn.ready;
    assign m_free   = ~m_vld_p1 | out_fire;

    always_comb begin
        m_vld_n  = m_vld_p1;
        m_ctrl_n = m_ctrl_p1;
        m_data_n = m_data_p1;
        s_vld_n  = s_vld_p1;
        s_ctrl_n = s_ctrl_p1;
        s_data_n = s_data_p1;
        if (flush_i) begin
            m_vld_n  = 1'b0;
            s_vld_n  = 1'b0;
            m_ctrl_n = '0;
            s_ctrl_n = '0;
        end else if (m_free) begin
            if (s_vld_p1) begin
                m_vld_n  = 1'b1;
                m_ctrl_n = s_ctrl_p1;
                m_data_n = s_data_p1;
                s_vld_n  = 1'b0;
            end else if (in_fire) begin
                m_vld_n  = 1'b1;
                m_ctrl_n = up.ctrl;
                m_data_n = up.data;
            end else begin
                m_vld_n  = 1'b0;
            end
        end else if (in_fire && HAS_SKID) begin
            s_vld_n  = 1'b1;
            s_ctrl_n = up.ctrl;
            s_data_n = up.data;
        end
    end

    // Stage boundary: held entries
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rst_done  <= 1'b0;
            m_vld_p1  <= 1'b0;
            m_ctrl_p1 <= '0;
            m_data_p1 <= '0;
            s_vld_p1  <= 1'b0;
            s_ctrl_p1 <= '0;
            s_data_p1 <= '0;
        end else begin
            rst_done  <= 1'b1;
            m_vld_p1  <= m_vld_n;
            m_ctrl_p1 <= m_ctrl_n;
            m_data_p1 <= m_data_n;
            s_vld_p1  <= s_vld_n;
            s_ctrl_p1 <= s_ctrl_n;
            s_data_p1 <= s_data_n;
        end
    end

    assign up.ready = ready;
    assign dn.valid = m_vld_p1;
    assign dn.ctrl  = m_ctrl_p1;
    assign dn.data  = m_data_p1;
    assign count_o  = {1'b0, m_vld_p1} + {1'b0, s_vld_p1};
endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: one skid-buffered instance (a_*) and one single-entry instance (b_*).
module tb_pipe_stage_buf;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       a_flush = 1'b0;
    logic       b_flush = 1'b0;
    logic [1:0] a_cnt;
    logic [1:0] b_cnt;
    int         checks = 0;
    int         errors = 0;

    pipe_stage_buf_if #(.CTRL_W(8), .DATA_W(16)) a_up ();
    pipe_stage_buf_if #(.CTRL_W(8), .DATA_W(16)) a_dn ();
    pipe_stage_buf_if #(.CTRL_W(8), .DATA_W(16)) b_up ();
    pipe_stage_buf_if #(.CTRL_W(8), .DATA_W(16)) b_dn ();

    pipe_stage_buf #(.CTRL_W(8), .DATA_W(16), .SKID(1)) u_skid (
        .clk_i(clk), .rst_i(rst_n), .up(a_up), .dn(a_dn), .flush_i(a_flush), .count_o(a_cnt)
    );
    pipe_stage_buf #(.CTRL_W(8), .DATA_W(16), .SKID(0)) u_noskid (
        .clk_i(clk), .rst_i(rst_n), .up(b_up), .dn(b_dn), .flush_i(b_flush), .count_o(b_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic a_drive(input logic v, input logic [7:0] c, input logic [15:0] d);
        a_up.valid = v;
        a_up.ctrl  = c;
        a_up.data  = d;
    endtask

    task automatic b_drive(input logic v, input logic [7:0] c, input logic [15:0] d);
        b_up.valid = v;
        b_up.ctrl  = c;
        b_up.data  = d;
    endtask

    task automatic test_reset();
        a_drive(1'b1, 8'h11, 16'h0011);
        b_drive(1'b0, 8'h00, 16'h0000);
        a_dn.ready = 1'b0;
        b_dn.ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) step();
        checks++;
        if ({a_dn.valid, a_up.ready, a_cnt, a_dn.ctrl, a_dn.data} !== {1'b0, 1'b0, 2'd0, 8'h00, 16'h0000}) begin
            errors++;
            $display("FAIL reset_hold got v=%b r=%b cnt=%0d ctrl=%h data=%h", a_dn.valid, a_up.ready, a_cnt, a_dn.ctrl, a_dn.data);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if ({a_dn.valid, a_up.ready, a_cnt, a_dn.ctrl, b_up.ready} !== {1'b0, 1'b0, 2'd0, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL reset_release got v=%b r=%b cnt=%0d ctrl=%h b_r=%b exp all 0", a_dn.valid, a_up.ready, a_cnt, a_dn.ctrl, b_up.ready);
        end
        step();
        checks++;
        if ({a_dn.valid, a_up.ready, a_cnt} !== {1'b0, 1'b1, 2'd0}) begin
            errors++;
            $display("FAIL reset_first_edge got v=%b r=%b cnt=%0d exp v=0 r=1 cnt=0", a_dn.valid, a_up.ready, a_cnt);
        end
        step();
        checks++;
        if ({a_dn.valid, a_dn.ctrl, a_dn.data, a_cnt} !== {1'b1, 8'h11, 16'h0011, 2'd1}) begin
            errors++;
            $display("FAIL reset_first_beat got v=%b ctrl=%h data=%h cnt=%0d exp 1 11 0011 1", a_dn.valid, a_dn.ctrl, a_dn.data, a_cnt);
        end
        a_drive(1'b0, 8'h00, 16'h0000);
        a_dn.ready = 1'b1;
        step();
        checks++;
        if ({a_dn.valid, a_cnt} !== {1'b0, 2'd0}) begin
            errors++;
            $display("FAIL reset_drain got v=%b cnt=%0d exp 0 0", a_dn.valid, a_cnt);
        end
    endtask

    task automatic test_streaming();
        a_dn.ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            a_drive(1'b1, 8'(i), 16'h0100 + 16'(i));
            step();
            checks++;
            if ({a_dn.valid, a_dn.ctrl, a_dn.data, a_cnt} !== {1'b1, 8'(i), 16'h0100 + 16'(i), 2'd1}) begin
                errors++;
                $display("FAIL stream_beat%0d got v=%b ctrl=%h data=%h cnt=%0d exp ctrl=%h cnt=1", i, a_dn.valid, a_dn.ctrl, a_dn.data, a_cnt, 8'(i));
            end
        end
        a_drive(1'b0, 8'h00, 16'h0000);
        step();
        checks++;
        if ({a_dn.valid, a_cnt} !== {1'b0, 2'd0}) begin
            errors++;
            $display("FAIL stream_end got v=%b cnt=%0d exp 0 0", a_dn.valid, a_cnt);
        end
    endtask

    task automatic test_stall_fill();
        a_dn.ready = 1'b0;
        a_drive(1'b1, 8'hA1, 16'h00A1);
        step();
        a_drive(1'b1, 8'hA2, 16'h00A2);
        step();
        a_drive(1'b0, 8'h00, 16'h0000);
        checks++;
        if ({a_cnt, a_up.ready, a_dn.valid, a_dn.ctrl, a_dn.data} !== {2'd2, 1'b0, 1'b1, 8'hA1, 16'h00A1}) begin
            errors++;
            $display("FAIL stall_full got cnt=%0d r=%b v=%b ctrl=%h data=%h exp 2 0 1 A1 00A1", a_cnt, a_up.ready, a_dn.valid, a_dn.ctrl, a_dn.data);
        end
        step();
        checks++;
        if ({a_cnt, a_dn.ctrl, a_dn.data} !== {2'd2, 8'hA1, 16'h00A1}) begin
            errors++;
            $display("FAIL stall_hold got cnt=%0d ctrl=%h data=%h exp 2 A1 00A1", a_cnt, a_dn.ctrl, a_dn.data);
        end
        a_dn.ready = 1'b1;
        step();
        checks++;
        if ({a_cnt, a_up.ready, a_dn.valid, a_dn.ctrl, a_dn.data} !== {2'd1, 1'b1, 1'b1, 8'hA2, 16'h00A2}) begin
            errors++;
            $display("FAIL drain_first got cnt=%0d r=%b v=%b ctrl=%h data=%h exp 1 1 1 A2 00A2", a_cnt, a_up.ready, a_dn.valid, a_dn.ctrl, a_dn.data);
        end
        step();
        checks++;
        if ({a_cnt, a_dn.valid} !== {2'd0, 1'b0}) begin
            errors++;
            $display("FAIL drain_second got cnt=%0d v=%b exp 0 0", a_cnt, a_dn.valid);
        end
    endtask

    task automatic test_flush();
        a_dn.ready = 1'b0;
        a_drive(1'b1, 8'hB1, 16'h12B1);
        step();
        a_drive(1'b1, 8'hB2, 16'h12B2);
        step();
        a_drive(1'b1, 8'hFF, 16'hFFFF);
        a_flush = 1'b1;
        #1;
        checks++;
        if ({a_cnt, a_up.ready} !== {2'd2, 1'b0}) begin
            errors++;
            $display("FAIL flush_pre got cnt=%0d r=%b exp 2 0", a_cnt, a_up.ready);
        end
        step();
        a_flush = 1'b0;
        a_drive(1'b0, 8'h00, 16'h0000);
        #1;
        checks++;
        if ({a_dn.valid, a_dn.ctrl, a_cnt, a_dn.data, a_up.ready} !== {1'b0, 8'h00, 2'd0, 16'h12B1, 1'b1}) begin
            errors++;
            $display("FAIL flush_full got v=%b ctrl=%h cnt=%0d data=%h r=%b exp 0 00 0 12B1 1", a_dn.valid, a_dn.ctrl, a_cnt, a_dn.data, a_up.ready);
        end
        a_dn.ready = 1'b1;
        step();
        checks++;
        if ({a_dn.valid, a_dn.ctrl, a_cnt} !== {1'b0, 8'h00, 2'd0}) begin
            errors++;
            $display("FAIL flush_no_ff got v=%b ctrl=%h cnt=%0d exp 0 00 0", a_dn.valid, a_dn.ctrl, a_cnt);
        end
        b_dn.ready = 1'b1;
        b_drive(1'b1, 8'hEE, 16'h00EE);
        b_flush = 1'b1;
        step();
        b_flush = 1'b0;
        b_drive(1'b0, 8'h00, 16'h0000);
        checks++;
        if ({b_dn.valid, b_dn.ctrl, b_cnt} !== {1'b0, 8'h00, 2'd0}) begin
            errors++;
            $display("FAIL flush_in_fire got v=%b ctrl=%h cnt=%0d exp 0 00 0", b_dn.valid, b_dn.ctrl, b_cnt);
        end
    endtask

    task automatic test_noskid_backpressure();
        b_dn.ready = 1'b0;
        b_drive(1'b1, 8'hC1, 16'h00C1);
        #1;
        checks++;
        if (b_up.ready !== 1'b1) begin
            errors++;
            $display("FAIL noskid_empty_ready got %b exp 1", b_up.ready);
        end
        step();
        b_drive(1'b1, 8'hC2, 16'h00C2);
        #1;
        checks++;
        if ({b_up.ready, b_dn.valid, b_dn.ctrl} !== {1'b0, 1'b1, 8'hC1}) begin
            errors++;
            $display("FAIL noskid_stall got r=%b v=%b ctrl=%h exp 0 1 C1", b_up.ready, b_dn.valid, b_dn.ctrl);
        end
        step();
        checks++;
        if ({b_dn.valid, b_dn.ctrl, b_cnt} !== {1'b1, 8'hC1, 2'd1}) begin
            errors++;
            $display("FAIL noskid_hold got v=%b ctrl=%h cnt=%0d exp 1 C1 1", b_dn.valid, b_dn.ctrl, b_cnt);
        end
        b_dn.ready = 1'b1;
        #1;
        checks++;
        if (b_up.ready !== 1'b1) begin
            errors++;
            $display("FAIL noskid_comb_ready got %b exp 1", b_up.ready);
        end
        step();
        b_drive(1'b0, 8'h00, 16'h0000);
        checks++;
        if ({b_dn.valid, b_dn.ctrl, b_dn.data, b_cnt} !== {1'b1, 8'hC2, 16'h00C2, 2'd1}) begin
            errors++;
            $display("FAIL noskid_next got v=%b ctrl=%h data=%h cnt=%0d exp 1 C2 00C2 1", b_dn.valid, b_dn.ctrl, b_dn.data, b_cnt);
        end
        step();
        checks++;
        if ({b_dn.valid, b_cnt} !== {1'b0, 2'd0}) begin
            errors++;
            $display("FAIL noskid_drain got v=%b cnt=%0d exp 0 0", b_dn.valid, b_cnt);
        end
    endtask

    task automatic test_async_reset();
        a_dn.ready = 1'b0;
        a_drive(1'b1, 8'hD1, 16'h00D1);
        step();
        a_drive(1'b1, 8'hD2, 16'h00D2);
        step();
        a_drive(1'b0, 8'h00, 16'h0000);
        checks++;
        if (a_cnt !== 2'd2) begin
            errors++;
            $display("FAIL async_prefill got cnt=%0d exp 2", a_cnt);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({a_dn.valid, a_cnt, a_dn.ctrl, a_dn.data, a_up.ready} !== {1'b0, 2'd0, 8'h00, 16'h0000, 1'b0}) begin
            errors++;
            $display("FAIL async_reset got v=%b cnt=%0d ctrl=%h data=%h r=%b exp all 0", a_dn.valid, a_cnt, a_dn.ctrl, a_dn.data, a_up.ready);
        end
        step();
        rst_n = 1'b1;
        a_drive(1'b1, 8'hD3, 16'h00D3);
        a_dn.ready = 1'b1;
        step();
        checks++;
        if ({a_dn.valid, a_up.ready} !== {1'b0, 1'b1}) begin
            errors++;
            $display("FAIL async_recover_edge got v=%b r=%b exp 0 1", a_dn.valid, a_up.ready);
        end
        step();
        a_drive(1'b0, 8'h00, 16'h0000);
        checks++;
        if ({a_dn.valid, a_dn.ctrl, a_cnt} !== {1'b1, 8'hD3, 2'd1}) begin
            errors++;
            $display("FAIL async_recover_beat got v=%b ctrl=%h cnt=%0d exp 1 D3 1", a_dn.valid, a_dn.ctrl, a_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_stall_fill();
        test_flush();
        test_noskid_backpressure();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
Parametrised pipeline stage register. It replaces the fixed, always-loading inter-stage latches with a valid/ready stage that supports back-pressure (stall), flush (bubble insertion) and an optional 2-entry skid buffer. The payload is split into a control field, which is zeroed on flush, and a data field, which is not. It sits between any two CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB), with hazard and branch logic driving ready_i and flush_i.

Parameters:
CTRL_W, 8, width of control field (RegWrite, MemtoReg, MemRead, MemWrite, ALUSrc, ALUOp, ...); min 1
DATA_W, 128, width of data field (operands, register addresses, funct, imm); min 1
SKID, 1, 1 = 2-entry skid buffer with registered ready_o; 0 = single entry with combinational ready_o

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-low
valid_i  in  1  upstream beat valid
ready_o  out  1  stage can accept a beat
ctrl_i  in  CTRL_W  upstream control field
data_i  in  DATA_W  upstream data field
flush_i  in  1  kill all held beats (synchronous)
valid_o  out  1  downstream beat valid
ready_i  in  1  downstream accepts; low = stall
ctrl_o  out  CTRL_W  control field of head entry
data_o  out  DATA_W  data field of head entry
count_o  out  2  number of valid entries (0..2; max 1 when SKID=0)

Behaviour:
- Definitions: in_fire = valid_i & ready_o; out_fire = valid_o & ready_i. Entry M (main) drives valid_o, ctrl_o and data_o. Entry S (skid) exists only when SKID=1.
- Reset (rst_i low, asynchronous): M and S are invalid; ctrl_o = 0, data_o = 0, valid_o = 0, count_o = 0, ready_o = 0.
- An internal rst_done flop clears on reset and sets on the first clk_i edge after release. ready_o is forced to 0 until rst_done = 1, so no beat is accepted in the cycle reset deasserts.
- SKID=1: ready_o = rst_done & ~S.valid. It is driven from flops only, with no combinational path from ready_i.
- SKID=0: ready_o = rst_done & (~M.valid | ready_i). This path is combinational.
- Latency: 1 cycle. A beat accepted at edge N appears on valid_o/ctrl_o/data_o after edge N when M was empty or out_fire was true.
- Update rules, evaluated per rising edge with no flush:
  - M empty or out_fire, S valid: M <- S; S becomes invalid. in_fire cannot occur here because ready_o = 0.
  - M empty or out_fire, S invalid, in_fire: M <- input.
  - M empty or out_fire, S invalid, no in_fire: M becomes invalid.
  - M valid, no out_fire, in_fire (SKID=1 only): S <- input.
  - M valid, no out_fire, no in_fire: hold. Outputs are stable and bit-identical while stalled.
- Ordering: beats leave in acceptance order. No beat is duplicated or dropped except by flush.
- Flush (flush_i=1 at an edge):
  - Flush has priority over every other update.
  - After the edge, M and S are invalid, ctrl_o = 0, and count_o = 0. data_o holds its previous value.
  - A beat with in_fire in the flush cycle is discarded.
  - A beat with out_fire in the flush cycle counts as delivered.
  - ready_o is unaffected by flush_i in that cycle. In the next cycle it is 1 (SKID=1, since S is empty).
- count_o = M.valid + S.valid, registered.
- Reset mid-operation: all state clears immediately and asynchronously; the stage behaves as after power-on.
- Stall with full buffer (SKID=1, count_o=2): ready_o = 0, both entries hold. When ready_i rises, M drains S over two consecutive out_fires. ready_o returns to 1 the cycle after the first out_fire.

Test Plan:
- Reset release: hold rst_i=0 for 3 cycles, then release with valid_i=1 -> valid_o=0, ctrl_o=0, count_o=0, ready_o=0 in the first cycle after release; first beat accepted at the second edge.
- Streaming: ready_i=1, beats ctrl=8'h01..8'h05 on consecutive cycles -> ctrl_o emits 01..05 on consecutive cycles, 1-cycle latency, count_o stays 1.
- Stall fill, SKID=1: M holds 8'hA1, ready_i=0, input 8'hA2 -> count_o=2, ready_o=0, ctrl_o held at A1. Raise ready_i -> ctrl_o A1 then A2 on consecutive cycles; count_o goes 2,1,0 with no new input.
- Flush with full buffer: count_o=2, valid_i=1 with 8'hFF, flush_i=1 for one edge -> valid_o=0, ctrl_o=0, count_o=0, data_o unchanged; 8'hFF never appears.
- SKID=0 back-pressure: M valid, ready_i=0 -> ready_o=0. Set ready_i=1 with valid_i=1 -> same-cycle ready_o=1; new beat in M after the edge.
- Async reset mid-stall: count_o=2, drop rst_i between clock edges -> valid_o, count_o and ctrl_o go to 0 without waiting for a clock edge.
